// File: rtl/sm_seq_pkg.sv
// Shared state encodings and error codes for the sm_seq_check sequence monitor.
package sm_seq_pkg;

  // One-hot with an all-zero idle state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RUN   = 3'b001,
    ST_DONE  = 3'b010,
    ST_ERROR = 3'b100
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/sm_seq_timer.sv
// Idle-cycle counter: expire fires on the tick that would be the TIMEOUT-th
// consecutive idle cycle since the last clear.
module sm_seq_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = tick && !clear && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_seq_check.sv
// Programmable ordered-sequence checker with sticky error and registered outputs.
// Define SM_SEQ_TIMEOUT_EN to compile in the RUN-state inactivity timeout.
module sm_seq_check
  import sm_seq_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned SW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clr,
  input  logic            in_vld,
  input  logic [W-1:0]    in_sym,
  input  logic [N*W-1:0]  exp_seq,
  output logic            busy,
  output logic [SW-1:0]   step,
  output logic            match,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code
);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          match_q, match_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [W-1:0]  exp_sym;
  logic          expire;

  assign exp_sym = exp_seq[32'(step_q) * W +: W];

`ifdef SM_SEQ_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_tick;

  // Any valid symbol or control event in RUN restarts the idle count.
  assign tmr_clear = (state_q != ST_RUN) || in_vld || start || clr;
  assign tmr_tick  = (state_q == ST_RUN) && !in_vld;

  sm_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .tick   (tmr_tick),
    .expire (expire)
  );
`else
  // TIMEOUT is at least 1, so this is a constant low.
  assign expire = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!clr && start) begin
          state_d = ST_RUN;
          step_d  = '0;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (start) begin
          step_d = '0;
        end else if (in_vld) begin
          if (in_sym == exp_sym) begin
            match_d = 1'b1;
            if (step_q == SW'(N - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              step_d  = '0;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            code_d  = ERR_MISMATCH;
          end
        end else if (expire) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_DONE: begin
        state_d = (!clr && start) ? ST_RUN : ST_IDLE;
        step_d  = '0;
      end
      ST_ERROR: begin
        if (clr) begin
          state_d = ST_IDLE;
          step_d  = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      match_q <= match_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign step     = step_q;
  assign match    = match_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_sm_seq_check.sv
// Self-checking bench for sm_seq_check: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_sm_seq_check;

  localparam int W       = 4;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int SW      = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            clr = 1'b0;
  logic            in_vld = 1'b0;
  logic [W-1:0]    in_sym = '0;
  logic [N*W-1:0]  exp_seq = 16'hDCBA;
  logic            busy;
  logic [SW-1:0]   step;
  logic            match;
  logic            done;
  logic            err;
  logic [1:0]      err_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 just finished, 3 error.
  int         m_mode = 0;
  int         m_step = 0;
  int         m_idle = 0;
  bit         m_match = 0;
  bit         m_done = 0;
  logic [1:0] m_code = 2'b00;

  sm_seq_check #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clr      (clr),
    .in_vld   (in_vld),
    .in_sym   (in_sym),
    .exp_seq  (exp_seq),
    .busy     (busy),
    .step     (step),
    .match    (match),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sym_at(input int k);
    return exp_seq[k*W +: W];
  endfunction

  task automatic model_edge();
    m_match = 0;
    m_done  = 0;
    if (rst) begin
      m_mode = 0; m_step = 0; m_code = 2'b00; m_idle = 0;
      return;
    end
    if (m_mode == 3) begin
      if (clr) begin m_mode = 0; m_step = 0; m_code = 2'b00; end
      return;
    end
    if (clr) begin m_mode = 0; m_step = 0; return; end
    if (start) begin m_mode = 1; m_step = 0; m_idle = 0; return; end
    if (m_mode != 1) begin m_mode = 0; m_step = 0; return; end
    if (in_vld) begin
      m_idle = 0;
      if (in_sym == sym_at(m_step)) begin
        m_match = 1;
        if (m_step == N - 1) begin m_mode = 2; m_done = 1; m_step = 0; end
        else m_step = m_step + 1;
      end else begin
        m_mode = 3; m_code = 2'b01;
      end
    end else begin
      m_idle = m_idle + 1;
`ifdef SM_SEQ_TIMEOUT_EN
      if (m_idle == TIMEOUT) begin m_mode = 3; m_code = 2'b10; end
`endif
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic drive(input bit s, input bit c, input bit v, input logic [W-1:0] sy);
    start = s; clr = c; in_vld = v; in_sym = sy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom));
      tick();
    end
    if ({busy, step, match, done, err, err_code} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%0b step=%0d match=%0b done=%0b err=%0b code=%0d want all 0",
               busy, step, match, done, err, err_code);
    end
    n_checks++;
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got busy=%0b err=%0b want 0 0", busy, err);
    end
    n_checks++;
  endtask

  task automatic test_happy();
    logic [W-1:0] syms [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    drive(1, 0, 0, 0);
    tick();
    if (busy !== 1'b1 || step !== 2'd0) begin
      n_fail++; $display("FAIL happy_start got busy=%0b step=%0d want 1 0", busy, step);
    end
    n_checks++;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, syms[k]);
      tick();
      if (match !== 1'b1 || step !== SW'((k + 1) % 4) || done !== (k == 3)) begin
        n_fail++;
        $display("FAIL happy_sym%0d got match=%0b step=%0d done=%0b want 1 %0d %0b",
                 k, match, step, done, (k + 1) % 4, k == 3);
      end
      n_checks++;
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL happy_done_busy got %0b want 0", busy);
    end
    n_checks++;
    drive(0, 0, 0, 0);
    tick();
    if (done !== 1'b0 || match !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL happy_after got done=%0b match=%0b busy=%0b want 0 0 0", done, match, busy);
    end
    n_checks++;
  endtask

  task automatic test_mismatch();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 1, 4'hA); tick();
    drive(0, 0, 1, 4'h5); tick();
    for (int i = 0; i < 10; i++) begin
      if (err !== 1'b1 || err_code !== 2'b01 || step !== 2'd1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mismatch_hold%0d got err=%0b code=%0d step=%0d busy=%0b want 1 1 1 0",
                 i, err, err_code, step, busy);
      end
      n_checks++;
      drive($urandom_range(0, 1), 0, $urandom_range(0, 1), 4'($urandom));
      tick();
    end
    drive(0, 1, 0, 0); tick();
    if (err !== 1'b0 || err_code !== 2'b00 || step !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_clr got err=%0b code=%0d step=%0d busy=%0b want 0 0 0 0", err, err_code, step, busy);
    end
    n_checks++;
    drive(0, 0, 0, 0); tick();
  endtask

`ifdef SM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 1, 4'hA); tick();
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15 && err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early got err=%0b want 0", err);
      end
      if (i == 15) n_checks++;
    end
    if (err !== 1'b1 || err_code !== 2'b10 || step !== 2'd1) begin
      n_fail++; $display("FAIL timeout_fire got err=%0b code=%0d step=%0d want 1 2 1", err, err_code, step);
    end
    n_checks++;
    drive(0, 1, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 1, 4'hA); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    drive(0, 0, 1, 4'hB); tick();
    if (err !== 1'b0 || step !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_edge got err=%0b step=%0d busy=%0b want 0 2 1", err, step, busy);
    end
    n_checks++;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
  endtask
`endif

  task automatic test_gaps_restart();
    drive(1, 0, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0);
      for (int g = 0; g < 3; g++) tick();
      drive(0, 0, 1, sym_at(k)); tick();
    end
    if (done !== 1'b1 || match !== 1'b1) begin
      n_fail++; $display("FAIL gaps_done got done=%0b match=%0b want 1 1", done, match);
    end
    n_checks++;
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 1, 4'hA); tick();
    drive(0, 0, 1, 4'hB); tick();
    drive(1, 0, 1, 4'hC); tick();
    if (step !== 2'd0 || busy !== 1'b1 || match !== 1'b0) begin
      n_fail++; $display("FAIL restart got step=%0d busy=%0b match=%0b want 0 1 0", step, busy, match);
    end
    n_checks++;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, sym_at(k)); tick();
    end
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL restart_done got %0b want 1", done);
    end
    n_checks++;
    drive(0, 0, 0, 0); tick();
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL prio_clr_start got busy=%0b err=%0b want 0 0", busy, err);
    end
    n_checks++;
    drive(1, 0, 1, 4'hA); tick();
    if (busy !== 1'b1 || step !== 2'd0 || match !== 1'b0) begin
      n_fail++; $display("FAIL prio_start_vld got busy=%0b step=%0d match=%0b want 1 0 0", busy, step, match);
    end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, sym_at(k)); tick();
    end
    if (step !== 2'd3) begin
      n_fail++; $display("FAIL prio_pre_rst got step=%0d want 3", step);
    end
    n_checks++;
    rst = 1'b1;
    drive(0, 0, 1, 4'hD); tick();
    if ({busy, step, match, done, err, err_code} !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_rst got busy=%0b step=%0d match=%0b done=%0b err=%0b code=%0d want all 0",
               busy, step, match, done, err, err_code);
    end
    n_checks++;
    rst = 1'b0;
    drive(0, 0, 0, 0); tick();
  endtask

  task automatic test_random();
    int vld_pct;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    exp_seq = 16'($urandom);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      vld_pct = ((i / 250) % 2 == 1) ? 4 : 60;
      start  = ($urandom_range(0, 29) == 0);
      clr    = ($urandom_range(0, 59) == 0);
      in_vld = ($urandom_range(0, 99) < vld_pct);
      in_sym = ($urandom_range(0, 99) < 85) ? sym_at(m_step) : 4'($urandom);
      tick();
      if (busy !== (m_mode == 1)) begin
        n_fail++; $display("FAIL rnd_busy cyc=%0d got %0b want %0b", i, busy, m_mode == 1);
      end
      if (step !== SW'(m_step)) begin
        n_fail++; $display("FAIL rnd_step cyc=%0d got %0d want %0d", i, step, m_step);
      end
      if (match !== m_match) begin
        n_fail++; $display("FAIL rnd_match cyc=%0d got %0b want %0b", i, match, m_match);
      end
      if (done !== m_done) begin
        n_fail++; $display("FAIL rnd_done cyc=%0d got %0b want %0b", i, done, m_done);
      end
      if (err !== (m_mode == 3)) begin
        n_fail++; $display("FAIL rnd_err cyc=%0d got %0b want %0b", i, err, m_mode == 3);
      end
      if (err_code !== m_code) begin
        n_fail++; $display("FAIL rnd_code cyc=%0d got %0d want %0d", i, err_code, m_code);
      end
      n_checks += 6;
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_mismatch();
`ifdef SM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_gaps_restart();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
